// File: rtl/svm_det_if.sv
// svm_det_if: classifier-result input, hit readout and frame status of the
// SVM detection collector. SVM_DET_BEST_TRACK_EN adds the best-hit outputs.
interface svm_det_if #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 28,
    parameter int SW_W  = 11
);
    localparam int SC = FEA_I + FEA_F;

    logic            i_valid;
    logic            i_is_person;
    logic [SC-1:0]   i_score;
    logic [SW_W-1:0] i_sw_id;
    logic [SC-1:0]   i_thresh;
    logic            o_det_valid;
    logic [SW_W-1:0] o_det_sw_id;
    logic [SC-1:0]   o_det_score;
    logic            i_det_ready;
    logic            o_frame_done;
    logic [SW_W:0]   o_frame_hits;
    logic            o_overflow;
    logic            o_seq_err;
`ifdef SVM_DET_BEST_TRACK_EN
    logic            o_best_valid;
    logic [SW_W-1:0] o_best_sw_id;
    logic [SC-1:0]   o_best_score;

    modport master (
        output i_valid, i_is_person, i_score, i_sw_id, i_thresh, i_det_ready,
        input  o_det_valid, o_det_sw_id, o_det_score, o_frame_done, o_frame_hits,
               o_overflow, o_seq_err, o_best_valid, o_best_sw_id, o_best_score
    );
    modport slave (
        input  i_valid, i_is_person, i_score, i_sw_id, i_thresh, i_det_ready,
        output o_det_valid, o_det_sw_id, o_det_score, o_frame_done, o_frame_hits,
               o_overflow, o_seq_err, o_best_valid, o_best_sw_id, o_best_score
    );
`else
    modport master (
        output i_valid, i_is_person, i_score, i_sw_id, i_thresh, i_det_ready,
        input  o_det_valid, o_det_sw_id, o_det_score, o_frame_done, o_frame_hits,
               o_overflow, o_seq_err
    );
    modport slave (
        input  i_valid, i_is_person, i_score, i_sw_id, i_thresh, i_det_ready,
        output o_det_valid, o_det_sw_id, o_det_score, o_frame_done, o_frame_hits,
               o_overflow, o_seq_err
    );
`endif
endinterface

// File: rtl/svm_det_collector.sv
// svm_det_collector: gates classifier results against a signed threshold,
// queues hit windows in a FWFT FIFO and tracks frames by window id.
// Optional macro SVM_DET_BEST_TRACK_EN: per-frame best-scoring hit outputs.
module svm_det_collector #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 28,
    parameter int SW_W   = 11,
    parameter int NUM_SW = 1200,
    parameter int DEPTH  = 16
) (
    input  logic     clk,
    input  logic     rst,
    svm_det_if.slave bus
);
    localparam int SC = FEA_I + FEA_F;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = SW_W + 1;
    localparam logic [SW_W-1:0] LAST_ID = SW_W'(NUM_SW - 1);
    localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t          r_state;
    logic [SW_W-1:0] r_prev_id;
    logic [CW-1:0]   r_cnt;
    logic            r_seq_err;
    logic            r_s1_push, r_s1_clr, r_s1_last;
    logic [SW_W-1:0] r_s1_id;
    logic [SC-1:0]   r_s1_score;
    logic            r_frame_done;
    logic [CW-1:0]   r_frame_hits;
    logic            r_overflow;
    logic [SW_W-1:0] r_mem_id [DEPTH];
    logic [SC-1:0]   r_mem_sc [DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [AW:0]     r_count;

    logic            w_hit, w_first, w_seq_ok, w_acc, w_last, w_pop, w_wr;
    logic [CW-1:0]   w_cnt_base, w_cnt_next;

    assign w_hit      = bus.i_valid & bus.i_is_person &
                        ($signed(bus.i_score) >= $signed(bus.i_thresh));
    assign w_first    = (r_state == ST_IDLE) && (bus.i_sw_id == '0);
    assign w_seq_ok   = (r_state == ST_FRAME) && (bus.i_sw_id == (r_prev_id + 1'b1));
    assign w_acc      = bus.i_valid & (w_first | w_seq_ok);
    assign w_last     = w_acc & (bus.i_sw_id == LAST_ID);
    // A new frame restarts the count from this window
    assign w_cnt_base = w_first ? '0 : r_cnt;
    assign w_cnt_next = (w_hit && (w_cnt_base != '1)) ? w_cnt_base + 1'b1 : w_cnt_base;

    // Frame sequencing FSM: accept in-order ids, flag and discard the rest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_prev_id <= '0;
            r_cnt     <= '0;
            r_seq_err <= 1'b0;
        end else if (bus.i_valid) begin
            if (w_acc) begin
                r_prev_id <= bus.i_sw_id;
                r_cnt     <= w_cnt_next;
                r_state   <= w_last ? ST_IDLE : ST_FRAME;
                if (w_first)
                    r_seq_err <= 1'b0;
            end else begin
                r_seq_err <= 1'b1;
                r_state   <= ST_IDLE;
            end
        end
    end

    // Stage 1: register the accepted result one cycle ahead of the FIFO write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_push  <= 1'b0;
            r_s1_clr   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_id    <= '0;
            r_s1_score <= '0;
        end else begin
            r_s1_push  <= w_acc & w_hit;
            r_s1_clr   <= w_acc & w_first;
            r_s1_last  <= w_last;
            r_s1_id    <= bus.i_sw_id;
            r_s1_score <= bus.i_score;
        end
    end

    // Frame completion: r_cnt already includes the last window here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_hits <= '0;
        end else begin
            r_frame_done <= r_s1_last;
            if (r_s1_last)
                r_frame_hits <= r_cnt;
        end
    end

    assign w_pop = bus.i_det_ready & (r_count != '0);
    // A full FIFO still takes the push when the head leaves on the same edge
    assign w_wr  = r_s1_push & ((r_count != FULL) | w_pop);

    // FIFO pointers/occupancy and sticky drop flag (drop wins over frame clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_s1_push && !w_wr)
                r_overflow <= 1'b1;
            else if (r_s1_clr)
                r_overflow <= 1'b0;
        end
    end

    // FIFO storage; reset flushes via the pointers, data needs no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_id[r_wp] <= r_s1_id;
            r_mem_sc[r_wp] <= r_s1_score;
        end
    end

    assign bus.o_det_valid  = (r_count != '0);
    assign bus.o_det_sw_id  = bus.o_det_valid ? r_mem_id[r_rp] : '0;
    assign bus.o_det_score  = bus.o_det_valid ? r_mem_sc[r_rp] : '0;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_frame_hits = r_frame_hits;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_seq_err    = r_seq_err;

`ifdef SVM_DET_BEST_TRACK_EN
    logic            r_run_vld, r_best_vld;
    logic [SW_W-1:0] r_run_id, r_best_id;
    logic [SC-1:0]   r_run_score, r_best_score;
    logic            w_run_base;

    assign w_run_base = w_first ? 1'b0 : r_run_vld;

    // Running max of the frame; strict compare keeps the earlier (lower) id on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_vld   <= 1'b0;
            r_run_id    <= '0;
            r_run_score <= '0;
        end else if (w_acc) begin
            if (w_hit && (!w_run_base || ($signed(bus.i_score) > $signed(r_run_score)))) begin
                r_run_vld   <= 1'b1;
                r_run_id    <= bus.i_sw_id;
                r_run_score <= bus.i_score;
            end else if (w_first) begin
                r_run_vld <= 1'b0;
            end
        end
    end

    // Publish alongside the frame-done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_vld   <= 1'b0;
            r_best_id    <= '0;
            r_best_score <= '0;
        end else if (r_s1_last) begin
            r_best_vld   <= r_run_vld;
            r_best_id    <= r_run_vld ? r_run_id : '0;
            r_best_score <= r_run_vld ? r_run_score : '0;
        end
    end

    assign bus.o_best_valid = r_best_vld;
    assign bus.o_best_sw_id = r_best_id;
    assign bus.o_best_score = r_best_score;
`endif
endmodule

// File: tb/tb_svm_det_collector.sv
// tb_svm_det_collector: directed frames plus randomized frames, all outputs
// compared every cycle against a queue-based behavioural model.
module tb_svm_det_collector;
    localparam int FEA_I  = 4;
    localparam int FEA_F  = 28;
    localparam int SC     = FEA_I + FEA_F;
    localparam int SW_W   = 6;
    localparam int NUM_SW = 24;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svm_det_if #(.FEA_I(FEA_I), .FEA_F(FEA_F), .SW_W(SW_W)) bus ();

    svm_det_collector #(.FEA_I(FEA_I), .FEA_F(FEA_F), .SW_W(SW_W),
                        .NUM_SW(NUM_SW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [SW_W-1:0] id;
        logic [SC-1:0]   sc;
    } ent_t;

    ent_t mq[$];
    int   m_exp_next, m_cnt, m_hits, p_hits, m_id;
    bit   m_seq, m_ovf, m_done, p_push, p_clr, p_last, m_pop, m_hit, m_acc;
    ent_t p_ent;
`ifdef SVM_DET_BEST_TRACK_EN
    bit   mb_run_v, m_best_v, p_bv;
    ent_t mb_run, m_best, p_best;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_exp_next = -1; m_cnt = 0; m_hits = 0; p_hits = 0;
            m_seq = 0; m_ovf = 0; m_done = 0; p_push = 0; p_clr = 0; p_last = 0;
`ifdef SVM_DET_BEST_TRACK_EN
            mb_run_v = 0; m_best_v = 0; p_bv = 0; mb_run = '0; m_best = '0; p_best = '0;
`endif
        end else begin
            // effects of the window taken one edge earlier
            m_pop = bus.i_det_ready && (mq.size() > 0);
            if (m_pop) void'(mq.pop_front());
            if (p_clr) m_ovf = 0;
            if (p_push) begin
                if (mq.size() < DEPTH) mq.push_back(p_ent);
                else m_ovf = 1;
            end
            m_done = p_last;
            if (p_last) begin
                m_hits = p_hits;
`ifdef SVM_DET_BEST_TRACK_EN
                m_best_v = p_bv;
                m_best   = p_bv ? p_best : '0;
`endif
            end
            p_push = 0; p_clr = 0; p_last = 0;
            // new window
            if (bus.i_valid) begin
                m_hit = bus.i_is_person && ($signed(bus.i_score) >= $signed(bus.i_thresh));
                m_id  = int'(bus.i_sw_id);
                m_acc = (m_exp_next < 0) ? (m_id == 0) : (m_id == m_exp_next);
                if (!m_acc) begin
                    m_seq = 1;
                    m_exp_next = -1;
                end else begin
                    if (m_id == 0) begin
                        m_seq = 0; m_cnt = 0; p_clr = 1;
`ifdef SVM_DET_BEST_TRACK_EN
                        mb_run_v = 0;
`endif
                    end
                    if (m_hit) begin
                        m_cnt++;
                        p_push = 1;
                        p_ent  = '{id: bus.i_sw_id, sc: bus.i_score};
`ifdef SVM_DET_BEST_TRACK_EN
                        if (!mb_run_v || $signed(bus.i_score) > $signed(mb_run.sc)) begin
                            mb_run_v = 1;
                            mb_run   = p_ent;
                        end
`endif
                    end
                    if (m_id == NUM_SW - 1) begin
                        p_last = 1; p_hits = m_cnt; m_exp_next = -1;
`ifdef SVM_DET_BEST_TRACK_EN
                        p_bv = mb_run_v; p_best = mb_run;
`endif
                    end else begin
                        m_exp_next = m_id + 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    bit chk_en = 0;
    int n_done = 0;
    int last_hits = 0;
    int popped[$];

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("det_valid", bus.o_det_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("det_sw_id", bus.o_det_sw_id, mq[0].id);
                chk("det_score", bus.o_det_score, mq[0].sc);
            end
            chk("overflow", bus.o_overflow, m_ovf);
            chk("seq_err", bus.o_seq_err, m_seq);
            chk("frame_done", bus.o_frame_done, m_done);
            chk("frame_hits", bus.o_frame_hits, m_hits);
`ifdef SVM_DET_BEST_TRACK_EN
            chk("best_valid", bus.o_best_valid, m_best_v);
            chk("best_sw_id", bus.o_best_sw_id, m_best.id);
            chk("best_score", bus.o_best_score, m_best.sc);
`endif
            if (bus.o_det_valid && bus.i_det_ready) popped.push_back(int'(bus.o_det_sw_id));
            if (bus.o_frame_done) begin
                n_done++;
                last_hits = int'(bus.o_frame_hits);
            end
        end
    end

    // ---------------- stimulus ----------------
    // inputs change 1 time unit after posedge and are sampled at the next posedge
    task automatic step(input bit v, input int id, input bit p,
                        input logic [SC-1:0] sc, input logic [SC-1:0] th, input bit rdy);
        @(posedge clk); #1;
        bus.i_valid     = v;
        bus.i_sw_id     = SW_W'(id);
        bus.i_is_person = p;
        bus.i_score     = sc;
        bus.i_thresh    = th;
        bus.i_det_ready = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, rdy);
    endtask

    task automatic frame_t1;
        for (int i = 0; i < NUM_SW; i++)
            step(1, i, (i == 2) || (i == 5), 32'h1000_0000, 32'h0, 1'b1);
        idle(4, 1'b1);
    endtask

    localparam logic [SC-1:0] ONE = 32'h1000_0000;
    logic [SC-1:0] th_r, sc_r;
    int            sid, rpct;

    initial begin
        rst = 1'b1;
        bus.i_valid = 0; bus.i_sw_id = '0; bus.i_is_person = 0;
        bus.i_score = '0; bus.i_thresh = '0; bus.i_det_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_det_valid", bus.o_det_valid, 0);
        chk("rst_det_id", bus.o_det_sw_id, 0);
        chk("rst_det_score", bus.o_det_score, 0);
        chk("rst_done", bus.o_frame_done, 0);
        chk("rst_hits", bus.o_frame_hits, 0);
        chk("rst_ovf", bus.o_overflow, 0);
        chk("rst_seq", bus.o_seq_err, 0);
        rst = 1'b0;
        chk_en = 1;

        // T1: basic frame, hits on ids 2 and 5
        popped.delete(); n_done = 0;
        frame_t1();
        chk("t1_done_cnt", n_done, 1);
        chk("t1_hits", last_hits, 2);
        chk("t1_pop_cnt", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t1_pop0", popped[0], 2);
            chk("t1_pop1", popped[1], 5);
        end
        chk("t1_ovf", bus.o_overflow, 0);
        chk("t1_seq", bus.o_seq_err, 0);

        // T2: threshold edges and signed compare
        popped.delete();
        step(1, 0, 1, 32'h0800_0000, 32'h0800_0000, 1);
        step(1, 1, 1, 32'h07FF_FFFF, 32'h0800_0000, 1);
        step(1, 2, 1, 32'hF800_0000, 32'hF000_0000, 1);
        step(1, 3, 1, 32'hF800_0000, 32'h0000_0000, 1);
        for (int i = 4; i < NUM_SW; i++) step(1, i, 0, ONE, 32'h0, 1);
        idle(4, 1);
        chk("t2_hits", last_hits, 2);
        chk("t2_pop_cnt", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("t2_pop0", popped[0], 0);
            chk("t2_pop1", popped[1], 2);
        end

        // T3: 20 hits with ready low -> 16 kept, overflow; then push+pop at full
        popped.delete();
        for (int i = 0; i < NUM_SW; i++) step(1, i, i < 20, ONE, 32'h0, 0);
        idle(3, 0);
        chk("t3_ovf", bus.o_overflow, 1);
        chk("t3_hits", last_hits, 20);
        chk("t3_full_valid", bus.o_det_valid, 1);
        step(1, 0, 1, ONE, 32'h0, 0);
        for (int i = 1; i < NUM_SW; i++) step(1, i, 1, ONE, 32'h0, 1);
        idle(DEPTH + 4, 1);
        chk("t3_no_drop_ovf", bus.o_overflow, 0);
        chk("t3_hits_b", last_hits, NUM_SW);
        chk("t3_pop_cnt", popped.size(), DEPTH + NUM_SW);
        if (popped.size() == DEPTH + NUM_SW) begin
            for (int i = 0; i < DEPTH; i++) chk("t3_pop_a", popped[i], i);
            for (int i = 0; i < NUM_SW; i++) chk("t3_pop_b", popped[DEPTH + i], i);
        end

        // T4: sequence error handling
        popped.delete();
        step(1, 0, 1, ONE, 32'h0, 1);
        step(1, 1, 1, ONE, 32'h0, 1);
        step(1, 3, 1, ONE, 32'h0, 1);
        step(1, 4, 1, ONE, 32'h0, 1);
        idle(3, 1);
        chk("t4_seq", bus.o_seq_err, 1);
        chk("t4_pop_cnt", popped.size(), 2);
        step(1, 0, 0, ONE, 32'h0, 1);
        idle(2, 1);
        chk("t4_seq_clr", bus.o_seq_err, 0);
        for (int i = 1; i < NUM_SW; i++) step(1, i, 0, ONE, 32'h0, 1);
        idle(4, 1);
        chk("t4_hits", last_hits, 0);

        // T5: reset mid-frame with 5 entries queued
        n_done = 0;
        for (int i = 0; i < 5; i++) step(1, i, 1, ONE, 32'h0, 0);
        idle(3, 0);
        chk("t5_pre_valid", bus.o_det_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_valid", bus.o_det_valid, 0);
        chk("t5_hits", bus.o_frame_hits, 0);
        chk("t5_seq", bus.o_seq_err, 0);
        chk("t5_ovf", bus.o_overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(NUM_SW, 1);
        chk("t5_no_done", n_done, 0);
        popped.delete();
        frame_t1();
        chk("t5_done_cnt", n_done, 1);
        chk("t5_frame_hits", last_hits, 2);
        chk("t5_pop_cnt", popped.size(), 2);

`ifdef SVM_DET_BEST_TRACK_EN
        // T6: best-hit tracking with a tie
        for (int i = 0; i < NUM_SW; i++) begin
            sc_r = (i == 3) ? 32'h0800_0000 : 32'h2000_0000;
            step(1, i, (i == 3) || (i == 6) || (i == 7), sc_r, 32'h0, 1);
        end
        idle(4, 1);
        chk("t6_best_valid", bus.o_best_valid, 1);
        chk("t6_best_id", bus.o_best_sw_id, 6);
        chk("t6_best_score", bus.o_best_score, 32'h2000_0000);
        for (int i = 0; i < NUM_SW; i++) step(1, i, 0, ONE, 32'h0, 1);
        idle(4, 1);
        chk("t6_nohit_valid", bus.o_best_valid, 0);
`endif

        // Random frames: gaps, id glitches, random backpressure and thresholds
        for (int f = 0; f < 30; f++) begin
            th_r = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            rpct = $urandom_range(10, 100);
            for (int i = 0; i < NUM_SW; i++) begin
                sid = i;
                if ($urandom_range(0, 99) < 4) sid = $urandom_range(0, NUM_SW - 1);
                if ($urandom_range(0, 4) == 0)
                    step(0, 0, 0, '0, th_r, $urandom_range(1, 100) <= rpct);
                sc_r = ($urandom_range(0, 2) == 0) ? th_r : $urandom;
                step(1, sid, $urandom_range(0, 1) == 1, sc_r, th_r,
                     $urandom_range(1, 100) <= rpct);
            end
        end
        idle(DEPTH + 4, 1);
        chk("end_empty", bus.o_det_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
